// File: rtl/dcoeff_bit_serializer.sv
// Bit-slice serializer for polynomial coefficients.
// Holds NCOEF coefficients of WIDTH bits each in circular shift registers.
// Emits one bit-slice per cycle: bit j of every coefficient, packed NCOEF wide.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   load, ddata                 capture packed coefficients (coef i at [i*WIDTH +: WIDTH])
//   start, msb_first            begin a run; the bit order is latched on an accepted start
//   repeat_en                   re-emit after the last slice (sampled on the last-slice cycle)
//   stop                        abort the current run and discard the data
//   dcoeff, slice_valid         current slice and its valid flag
//   bit_idx, last               slice index within the pass, and the final-slice flag
//   busy, loaded, done          run in progress, data held idle, pass-complete pulse
module dcoeff_bit_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCOEF = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NCOEF*WIDTH-1:0] ddata,
  input  logic                   start,
  input  logic                   msb_first,
  input  logic                   repeat_en,
  input  logic                   stop,
  output logic [NCOEF-1:0]       dcoeff,
  output logic                   slice_valid,
  output logic [CNT_W-1:0]       bit_idx,
  output logic                   last,
  output logic                   busy,
  output logic                   loaded,
  output logic                   done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [NCOEF-1:0][WIDTH-1:0] coef_q, coef_d;
  logic                        msb_q, msb_d;
  logic [CNT_W-1:0]            idx_q, idx_d;
  logic                        done_q, done_d;
  logic                        run_c;
  logic                        last_c;

  assign run_c  = (state_q == S_RUN);
  assign last_c = run_c && (idx_q == CNT_W'(WIDTH - 1));

  // Next-state: load/start handshake, rotation, pass completion and abort
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    msb_d   = msb_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          coef_d  = ddata;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (load) coef_d = ddata;
        if (start) begin
          msb_d   = msb_first;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // WIDTH rotations bring every register back to its loaded value
        for (int i = 0; i < NCOEF; i++) begin
          coef_d[i] = msb_q ? {coef_q[i][WIDTH-2:0], coef_q[i][WIDTH-1]}
                            : {coef_q[i][0], coef_q[i][WIDTH-1:1]};
        end
        if (stop) begin
          // Partially rotated data is unusable; force a reload
          coef_d  = '0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (last_c) begin
          idx_d = '0;
          if (!repeat_en) begin
            state_d = S_LOADED;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      coef_q  <= '0;
      msb_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      msb_q   <= msb_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Current slice taken from the emitting end of each register, zero when idle
  always_comb begin
    dcoeff = '0;
    for (int i = 0; i < NCOEF; i++) begin
      dcoeff[i] = run_c & (msb_q ? coef_q[i][WIDTH-1] : coef_q[i][0]);
    end
  end

  assign slice_valid = run_c;
  assign busy        = run_c;
  assign loaded      = (state_q == S_LOADED);
  assign bit_idx     = idx_q;
  assign last        = last_c;
  assign done        = done_q;

endmodule

// File: tb/tb_dcoeff_bit_serializer.sv
// Directed bench for dcoeff_bit_serializer (WIDTH=4, NCOEF=4).
// Each table row gives the inputs for one cycle and the outputs expected in
// that same cycle, before the rising edge consumes the inputs.
module tb_dcoeff_bit_serializer;

  localparam logic [15:0] D = 16'h0F3A;
  localparam logic [15:0] F = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset, load, start, msb_first, repeat_en, stop;
  logic [15:0] ddata;
  logic [3:0]  dcoeff;
  logic        slice_valid, last, busy, loaded, done;
  logic [1:0]  bit_idx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        ld;
    logic [15:0] dd;
    logic        st, ms, rp, sp, rs;
    logic [3:0]  dc;
    logic        v;
    logic [1:0]  ix;
    logic        ls, b, lo, dn;
  } vec_t;

  vec_t tbl[$];

  dcoeff_bit_serializer #(.WIDTH(4), .NCOEF(4)) dut (
    .clk(clk), .reset(reset), .load(load), .ddata(ddata), .start(start),
    .msb_first(msb_first), .repeat_en(repeat_en), .stop(stop),
    .dcoeff(dcoeff), .slice_valid(slice_valid), .bit_idx(bit_idx),
    .last(last), .busy(busy), .loaded(loaded), .done(done)
  );

  always #5 clk = ~clk;

  task automatic r(input logic ld, input logic [15:0] dd, input logic st, ms, rp, sp, rs,
                   input logic [3:0] dc, input logic v, input logic [1:0] ix,
                   input logic ls, b, lo, dn);
    vec_t e;
    e.ld = ld; e.dd = dd; e.st = st; e.ms = ms; e.rp = rp; e.sp = sp; e.rs = rs;
    e.dc = dc; e.v = v; e.ix = ix; e.ls = ls; e.b = b; e.lo = lo; e.dn = dn;
    tbl.push_back(e);
  endtask

  task automatic check(input string nm, input logic [3:0] dc, input logic v,
                       input logic [1:0] ix, input logic ls, b, lo, dn);
    n_vec++;
    if ({dcoeff, slice_valid, bit_idx, last, busy, loaded, done} !== {dc, v, ix, ls, b, lo, dn}) begin
      n_err++;
      $display("FAIL %s: got dcoeff=%b valid=%b idx=%0d last=%b busy=%b loaded=%b done=%b; expected dcoeff=%b valid=%b idx=%0d last=%b busy=%b loaded=%b done=%b",
               nm, dcoeff, slice_valid, bit_idx, last, busy, loaded, done, dc, v, ix, ls, b, lo, dn);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] dd, input logic st, ms, rp, sp, rs);
    load = ld; ddata = dd; start = st; msb_first = ms; repeat_en = rp; stop = sp; reset = rs;
  endtask

  initial begin
    logic [3:0] exp_dc;
    int         pos;

    drive(0, '0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);

    // Reset state; start in IDLE ignored
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    // Load 0F3A, LSB-first run
    r(1,D,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'h6,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h4,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h5,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,1,1);
    // MSB-first run on the same data
    r(0,0,1,1,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'h5,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h4,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h7,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h6,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,1,1);
    // LSB-first again: registers were restored
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'h6,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h4,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h5,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,1,1);
    // Repeat for two passes; load and start during RUN are ignored
    r(0,0,1,0,1,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,1,0,0, 4'h6,1,0,0,1,0,0);
    r(1,F,0,0,1,0,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,1,0,0, 4'h4,1,2,0,1,0,0);
    r(0,0,0,0,1,0,0, 4'h5,1,3,1,1,0,0);
    r(0,0,0,0,1,0,0, 4'h6,1,0,0,1,0,0);
    r(0,0,1,1,1,0,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,1,0,0, 4'h4,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h5,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,1,1);
    // Stop on the second slice; following start ignored
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'h6,1,0,0,1,0,0);
    r(0,0,0,0,0,1,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    // Stop on the last slice overrides repeat and completion
    r(1,D,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'h6,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h7,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h4,1,2,0,1,0,0);
    r(0,0,0,0,1,1,0, 4'h5,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    // Load+start in LOADED uses the new data
    r(1,D,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(1,F,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'hF,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'hF,1,1,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'hF,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'hF,1,3,1,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,1,1);
    // Reset on slice 3
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,1,0);
    r(0,0,0,0,0,0,0, 4'hF,1,0,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'hF,1,1,0,1,0,0);
    r(0,0,0,0,0,0,1, 4'hF,1,2,0,1,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,1,0,0,0,0, 4'h0,0,0,0,0,0,0);
    r(0,0,0,0,0,0,0, 4'h0,0,0,0,0,0,0);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].ld, tbl[k].dd, tbl[k].st, tbl[k].ms, tbl[k].rp, tbl[k].sp, tbl[k].rs);
      #1;
      check($sformatf("row%0d", k + 1), tbl[k].dc, tbl[k].v, tbl[k].ix,
            tbl[k].ls, tbl[k].b, tbl[k].lo, tbl[k].dn);
    end

    // MSB-first pass checked against a bit-position model of the loaded data
    @(negedge clk); drive(1, D, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, '0, 1, 1, 0, 0, 0);
    #1; check("seq_loaded", 4'h0, 0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); drive(0, '0, 0, 0, 0, 0, 0);
      #1;
      pos = 3 - j;
      for (int i = 0; i < 4; i++) exp_dc[i] = D[i*4 + pos];
      check($sformatf("seq_slice%0d", j), exp_dc, 1, 2'(j), (j == 3), 1, 0, 0);
    end
    @(negedge clk); #1; check("seq_done", 4'h0, 0, 0, 0, 0, 1, 1);
    @(negedge clk); #1; check("seq_done_clear", 4'h0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
